// File: rtl/rect_collide_if.sv
// Rectangle collision checker bus: frame strobe, control levels, two rectangles in,
// check result and status out.
interface rect_collide_if #(
  parameter int CW = 12
);
  logic          i_frame;
  logic          i_enable;
  logic          i_clear;
  logic [CW-1:0] i_a_x1, i_a_x2, i_a_y1, i_a_y2;
  logic [CW-1:0] i_b_x1, i_b_x2, i_b_y1, i_b_y2;
  logic          o_overlap;
  logic          o_hit;
  logic          o_hit_pulse;
  logic          o_busy;
  logic [15:0]   o_checks;

  modport master (
    output i_frame, i_enable, i_clear,
    output i_a_x1, i_a_x2, i_a_y1, i_a_y2,
    output i_b_x1, i_b_x2, i_b_y1, i_b_y2,
    input  o_overlap, o_hit, o_hit_pulse, o_busy, o_checks
  );

  modport slave (
    input  i_frame, i_enable, i_clear,
    input  i_a_x1, i_a_x2, i_a_y1, i_a_y2,
    input  i_b_x1, i_b_x2, i_b_y1, i_b_y2,
    output o_overlap, o_hit, o_hit_pulse, o_busy, o_checks
  );
endinterface

// File: rtl/rect_collide.sv
// Per-frame bird/obstacle overlap test: 2-stage compare pipeline feeding a
// debounce FSM that raises a sticky hit flag after HIT_FRAMES overlapping checks.
module rect_collide #(
  parameter int CW         = 12,
  parameter int HIT_FRAMES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  rect_collide_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, HIT} state_t;

  state_t        state;
  logic [3:0]    run;
  logic          v1, v2;
  logic [CW-1:0] ax1, ax2, ay1, ay2;
  logic [CW-1:0] bx1, bx2, by1, by2;
  logic          c_ax_lt_bx2, c_bx_lt_ax2, c_ay_lt_by2, c_by_lt_ay2;
  logic          a_empty, b_empty;

  logic          kill;
  logic          accept;
  logic          result;
  logic          res_valid;
  logic [4:0]    run_inc;

  // kill discards anything in flight: clear from any state, or disarm while ARMED
  always_comb begin
    kill      = bus.i_clear || (state == ARMED && !bus.i_enable);
    accept    = bus.i_frame && !v1 && (state != IDLE) && !kill;
    result    = c_ax_lt_bx2 && c_bx_lt_ax2 && c_ay_lt_by2 && c_by_lt_ay2
                && !a_empty && !b_empty;
    res_valid = v2 && !kill;
    run_inc   = {1'b0, run} + 5'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      bus.o_busy  <= 1'b0;
      ax1         <= '0;
      ax2         <= '0;
      ay1         <= '0;
      ay2         <= '0;
      bx1         <= '0;
      bx2         <= '0;
      by1         <= '0;
      by2         <= '0;
      c_ax_lt_bx2 <= 1'b0;
      c_bx_lt_ax2 <= 1'b0;
      c_ay_lt_by2 <= 1'b0;
      c_by_lt_ay2 <= 1'b0;
      a_empty     <= 1'b0;
      b_empty     <= 1'b0;
    end else begin
      v1         <= accept;
      v2         <= v1 && !kill;
      bus.o_busy <= accept || (v1 && !kill);
      if (accept) begin
        ax1 <= bus.i_a_x1;
        ax2 <= bus.i_a_x2;
        ay1 <= bus.i_a_y1;
        ay2 <= bus.i_a_y2;
        bx1 <= bus.i_b_x1;
        bx2 <= bus.i_b_x2;
        by1 <= bus.i_b_y1;
        by2 <= bus.i_b_y2;
      end
      if (v1) begin
        c_ax_lt_bx2 <= ax1 < bx2;
        c_bx_lt_ax2 <= bx1 < ax2;
        c_ay_lt_by2 <= ay1 < by2;
        c_by_lt_ay2 <= by1 < ay2;
        a_empty     <= (ax1 >= ax2) || (ay1 >= ay2);
        b_empty     <= (bx1 >= bx2) || (by1 >= by2);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      run             <= '0;
      bus.o_overlap   <= 1'b0;
      bus.o_hit       <= 1'b0;
      bus.o_hit_pulse <= 1'b0;
      bus.o_checks    <= '0;
    end else begin
      bus.o_hit_pulse <= 1'b0;
      if (bus.i_clear) begin
        state        <= IDLE;
        run          <= '0;
        bus.o_checks <= '0;
        bus.o_hit    <= 1'b0;
      end else begin
        if (res_valid) begin
          bus.o_overlap <= result;
          if (bus.o_checks != '1)
            bus.o_checks <= bus.o_checks + 16'd1;
        end
        case (state)
          IDLE: begin
            if (bus.i_enable)
              state <= ARMED;
          end
          ARMED: begin
            if (!bus.i_enable) begin
              state <= IDLE;
              run   <= '0;
            end else if (res_valid) begin
              if (result) begin
                run <= run_inc[3:0];
                if (run_inc == 5'(HIT_FRAMES)) begin
                  state           <= HIT;
                  bus.o_hit       <= 1'b1;
                  bus.o_hit_pulse <= 1'b1;
                end
              end else begin
                run <= '0;
              end
            end
          end
          HIT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rect_collide.sv
// Directed bench for rect_collide with HIT_FRAMES=2: hand-computed expectations
// checked by immediate assertions along one linear stimulus sequence.
module tb_rect_collide;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rect_collide_if #(.CW(12)) bus ();

  rect_collide #(.CW(12), .HIT_FRAMES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic [11:0] x1, x2, y1, y2);
    bus.i_a_x1 = x1; bus.i_a_x2 = x2; bus.i_a_y1 = y1; bus.i_a_y2 = y2;
  endtask

  task automatic set_b(input logic [11:0] x1, x2, y1, y2);
    bus.i_b_x1 = x1; bus.i_b_x2 = x2; bus.i_b_y1 = y1; bus.i_b_y2 = y2;
  endtask

  task automatic run_check();
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_clear();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_frame  = 1'b0;
    bus.i_enable = 1'b0;
    bus.i_clear  = 1'b0;
    set_a(12'd100, 12'd140, 12'd200, 12'd230);
    set_b(12'd130, 12'd200, 12'd0, 12'd215);

    // reset state
    repeat (3) tick();
    chk("rst_overlap", 16'(bus.o_overlap), 16'd0);
    chk("rst_hit", 16'(bus.o_hit), 16'd0);
    chk("rst_pulse", 16'(bus.o_hit_pulse), 16'd0);
    chk("rst_busy", 16'(bus.o_busy), 16'd0);
    chk("rst_checks", bus.o_checks, 16'd0);
    rst_n = 1'b1;

    // basic overlap, two strobes -> hit
    bus.i_enable = 1'b1;
    tick();
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    chk("busy_n1", 16'(bus.o_busy), 16'd1);
    tick();
    chk("overlap_n1", 16'(bus.o_overlap), 16'd0);
    chk("busy_n2", 16'(bus.o_busy), 16'd1);
    tick();
    chk("overlap_n2", 16'(bus.o_overlap), 16'd1);
    chk("checks_1", bus.o_checks, 16'd1);
    chk("hit_after1", 16'(bus.o_hit), 16'd0);
    chk("pulse_after1", 16'(bus.o_hit_pulse), 16'd0);
    chk("busy_after1", 16'(bus.o_busy), 16'd0);
    run_check();
    chk("pulse_hit", 16'(bus.o_hit_pulse), 16'd1);
    chk("hit_set", 16'(bus.o_hit), 16'd1);
    chk("checks_2", bus.o_checks, 16'd2);
    tick();
    chk("pulse_drop", 16'(bus.o_hit_pulse), 16'd0);
    chk("hit_sticky", 16'(bus.o_hit), 16'd1);

    // clear, then touching edges x5
    do_clear();
    chk("clr_hit", 16'(bus.o_hit), 16'd0);
    chk("clr_checks", bus.o_checks, 16'd0);
    tick();
    set_b(12'd140, 12'd200, 12'd0, 12'd215);
    repeat (5) run_check();
    chk("touch_overlap", 16'(bus.o_overlap), 16'd0);
    chk("touch_hit", 16'(bus.o_hit), 16'd0);
    chk("touch_checks", bus.o_checks, 16'd5);

    // streak break: ov, no, ov -> no hit; ov -> hit on 4th
    do_clear();
    tick();
    set_b(12'd130, 12'd200, 12'd0, 12'd215);
    run_check();
    set_b(12'd140, 12'd200, 12'd0, 12'd215);
    run_check();
    set_b(12'd130, 12'd200, 12'd0, 12'd215);
    run_check();
    chk("streak_hit", 16'(bus.o_hit), 16'd0);
    chk("streak_checks", bus.o_checks, 16'd3);
    chk("streak_overlap", 16'(bus.o_overlap), 16'd1);
    run_check();
    chk("streak4_pulse", 16'(bus.o_hit_pulse), 16'd1);
    chk("streak4_hit", 16'(bus.o_hit), 16'd1);
    chk("streak4_checks", bus.o_checks, 16'd4);

    // wrapped A while in HIT: checks still run, no overlap
    set_a(12'd4090, 12'd30, 12'd200, 12'd230);
    set_b(12'd0, 12'd100, 12'd0, 12'd479);
    run_check();
    chk("wrap_overlap", 16'(bus.o_overlap), 16'd0);
    chk("wrap_checks", bus.o_checks, 16'd5);
    bus.i_enable = 1'b0;
    tick();
    tick();
    chk("hit_ignores_en", 16'(bus.o_hit), 16'd1);
    bus.i_enable = 1'b1;

    // strobe while busy ignored
    do_clear();
    tick();
    set_a(12'd100, 12'd140, 12'd200, 12'd230);
    set_b(12'd130, 12'd200, 12'd0, 12'd215);
    bus.i_frame = 1'b1;
    tick();
    tick();
    bus.i_frame = 1'b0;
    tick();
    chk("busy_strobe_checks", bus.o_checks, 16'd1);
    chk("busy_strobe_busy", 16'(bus.o_busy), 16'd0);
    tick();
    chk("busy_strobe_nochk", bus.o_checks, 16'd1);

    // clear on the hit-producing result edge
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    tick();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    chk("clrhit_pulse", 16'(bus.o_hit_pulse), 16'd0);
    chk("clrhit_hit", 16'(bus.o_hit), 16'd0);
    chk("clrhit_checks", bus.o_checks, 16'd0);
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    tick();
    tick();
    chk("idle_strobe_checks", bus.o_checks, 16'd0);
    chk("idle_strobe_busy", 16'(bus.o_busy), 16'd0);

    // back-to-back checks two cycles apart
    set_b(12'd140, 12'd200, 12'd0, 12'd215);
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    tick();
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    chk("b2b_checks1", bus.o_checks, 16'd1);
    chk("b2b_busy", 16'(bus.o_busy), 16'd1);
    chk("b2b_overlap", 16'(bus.o_overlap), 16'd0);
    tick();
    tick();
    chk("b2b_checks2", bus.o_checks, 16'd2);
    chk("b2b_busy_end", 16'(bus.o_busy), 16'd0);

    // disable on the result edge discards the result
    set_b(12'd130, 12'd200, 12'd0, 12'd215);
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    tick();
    bus.i_enable = 1'b0;
    tick();
    chk("dis_checks", bus.o_checks, 16'd2);
    chk("dis_overlap", 16'(bus.o_overlap), 16'd0);
    chk("dis_busy", 16'(bus.o_busy), 16'd0);
    bus.i_enable = 1'b1;
    tick();

    // asynchronous reset mid-check
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    chk("mid_busy", 16'(bus.o_busy), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 16'(bus.o_busy), 16'd0);
    chk("arst_checks", bus.o_checks, 16'd0);
    chk("arst_overlap", 16'(bus.o_overlap), 16'd0);
    chk("arst_hit", 16'(bus.o_hit), 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_overlap", 16'(bus.o_overlap), 16'd0);
    chk("post_rst_checks", bus.o_checks, 16'd0);
    chk("post_rst_busy", 16'(bus.o_busy), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
